// File: rtl/timer_dev_pkg.sv
// Shared encodings for timer_dev: FSM states, register word offsets, CTRL
// field positions and MODE codes.
package timer_dev_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Byte offsets of the registers inside the window.
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;

  // Word index (praddr[3:2]) of each register; index 3 is an unmapped hole.
  localparam logic [1:0] IDX_CTRL   = OFF_CTRL[3:2];
  localparam logic [1:0] IDX_PRESET = OFF_PRESET[3:2];
  localparam logic [1:0] IDX_COUNT  = OFF_COUNT[3:2];
  localparam logic [1:0] IDX_HOLE   = 2'b11;

  // CTRL field positions.
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;
  localparam int CTRL_W        = 4;

  // MODE codes; 2'b1x falls back to one-shot behaviour.
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  function automatic logic is_auto(input logic [1:0] mode);
    return mode == MODE_AUTO;
  endfunction

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Decode, register file and the IDLE/LOAD/CNT/INT sequencer live inline here.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] praddr,
  input  logic [31:0] prwd,
  input  logic        prwe,
  output logic [31:0] prrd,
  output logic        irq
);

  // Byte lanes are not decoded; accesses are always full words.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^praddr[1:0];

  logic              hit;
  logic [1:0]        reg_idx;
  logic              ctrl_we;
  logic              preset_we;

  logic [CTRL_W-1:0] ctrl_q;
  logic [31:0]       preset_q;
  logic [31:0]       count_q;
  logic              pend_q;
  state_t            state_q;

  state_t            state_d;
  logic [31:0]       count_d;
  logic              fsm_en_clr;
  logic              pend_set;

  logic              en;
  logic              auto_mode;

  assign reg_idx   = praddr[3:2];
  assign hit       = (praddr[31:4] == BASE_ADDR[31:4]) && (reg_idx != IDX_HOLE);
  assign ctrl_we   = prwe && hit && (reg_idx == IDX_CTRL);
  assign preset_we = prwe && hit && (reg_idx == IDX_PRESET);

  assign en        = ctrl_q[CTRL_EN];
  assign auto_mode = is_auto(ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB]);

  // Sequencer next-state logic.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    fsm_en_clr = 1'b0;
    pend_set   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // A preset of 0 also lands here, so it times like a preset of 1.
          count_d  = 32'd0;
          state_d  = ST_INT;
          pend_set = !auto_mode;
        end
      end
      ST_INT: begin
        if (auto_mode) begin
          state_d = ST_LOAD;
        end else begin
          fsm_en_clr = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      count_q  <= 32'd0;
      ctrl_q   <= '0;
      preset_q <= 32'd0;
      pend_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (preset_we) preset_q <= prwd;
      // A CPU write to CTRL overrides the sequencer's self-disable.
      if (ctrl_we) begin
        ctrl_q <= prwd[CTRL_W-1:0];
      end else if (fsm_en_clr) begin
        ctrl_q[CTRL_EN] <= 1'b0;
      end
      // Setting the pending flag beats a simultaneous CTRL write clearing it.
      if (pend_set) begin
        pend_q <= 1'b1;
      end else if (ctrl_we) begin
        pend_q <= 1'b0;
      end
    end
  end

  always_comb begin
    prrd = 32'd0;
    if (hit) begin
      case (reg_idx)
        IDX_CTRL:   prrd = {{(32-CTRL_W){1'b0}}, ctrl_q};
        IDX_PRESET: prrd = preset_q;
        IDX_COUNT:  prrd = count_q;
        default:    prrd = 32'd0;
      endcase
    end
  end

  assign irq = ctrl_q[CTRL_IM] && (pend_q || ((state_q == ST_INT) && auto_mode));

endmodule

// File: tb/tb_timer_dev.sv
// Directed and randomized checks of timer_dev against a timeline-based
// reference model of the timer (run age since enable, not state registers).
module tb_timer_dev;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk;
  logic        rst;
  logic [31:0] praddr;
  logic [31:0] prwd;
  logic        prwe;
  logic [31:0] prrd;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ord;
  logic        oirq;

  timer_dev #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst   (rst),
    .praddr(praddr),
    .prwd  (prwd),
    .prwe  (prwe),
    .prrd  (prrd),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. A run starts on the edge where an idle, enabled timer
  // is noticed: age 1 is the load cycle, ages 2..lp+1 count, age lp+2 is the
  // interrupt cycle, with lp = max(preset,1) latched at the load.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic [31:0] m_pv;
  logic        m_pend;
  logic        m_run;
  longint      m_age;
  longint      m_lp;

  task automatic model_reset();
    m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_pv = 32'd0;
    m_pend = 1'b0; m_run = 1'b0; m_age = 0; m_lp = 1;
  endtask

  function automatic logic m_hit(input logic [31:0] a);
    return (a[31:4] == BASE[31:4]) && (a[3:2] != 2'b11);
  endfunction

  function automatic logic m_auto();
    return m_ctrl[2:1] == 2'b01;
  endfunction

  function automatic logic m_in_int();
    return m_run && (m_age == m_lp + 2);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!m_hit(a)) return 32'd0;
    case (a[3:2])
      2'b00:   return {28'd0, m_ctrl};
      2'b01:   return m_preset;
      default: return m_count;
    endcase
  endfunction

  function automatic logic model_irq();
    return m_ctrl[3] && (m_pend || (m_in_int() && m_auto()));
  endfunction

  task automatic model_edge(input logic r, input logic we, input logic [31:0] a,
                            input logic [31:0] d);
    logic       cw, pw, en, load, cnt, intc;
    logic [3:0] n_ctrl;
    logic       n_pend;
    if (!r) begin
      model_reset();
      return;
    end
    cw   = we && m_hit(a) && (a[3:2] == 2'b00);
    pw   = we && m_hit(a) && (a[3:2] == 2'b01);
    en   = m_ctrl[0];
    load = m_run && (m_age == 1);
    cnt  = m_run && (m_age >= 2) && (m_age <= m_lp + 1);
    intc = m_in_int();

    n_ctrl = m_ctrl;
    if (intc && !m_auto()) n_ctrl[0] = 1'b0;
    if (cw) n_ctrl = d[3:0];
    n_pend = m_pend;
    if (cw) n_pend = 1'b0;
    if (cnt && en && (m_age == m_lp + 1) && !m_auto()) n_pend = 1'b1;

    if (!m_run) begin
      if (en) begin m_run = 1'b1; m_age = 1; end
    end else if (load) begin
      m_age   = 2;
      m_pv    = m_preset;
      m_lp    = (m_preset == 32'd0) ? 1 : longint'(m_preset);
      m_count = m_preset;
    end else if (cnt) begin
      if (!en) begin
        m_run = 1'b0;
      end else begin
        m_age = m_age + 1;
        if (longint'(m_pv) > m_age - 2) m_count = m_pv - 32'(m_age - 2);
        else m_count = 32'd0;
      end
    end else if (intc) begin
      if (m_auto()) m_age = 1;
      else m_run = 1'b0;
    end

    m_ctrl = n_ctrl;
    m_pend = n_pend;
    if (pw) m_preset = d;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, sample away from the edge, compare to model, clock.
  task automatic step(input logic r, input logic we, input logic [31:0] a,
                      input logic [31:0] d);
    @(negedge clk);
    rst = r; prwe = we; praddr = a; prwd = d;
    #1;
    ord  = prrd;
    oirq = irq;
    check("model_rd", ord, model_read(a));
    check("model_irq", {31'd0, oirq}, {31'd0, model_irq()});
    @(posedge clk);
    model_edge(r, we, a, d);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b1, 1'b0, a, 32'd0);
  endtask

  initial begin
    logic        r, we;
    logic [31:0] a, d;
    int          sel;

    rst = 1'b0; prwe = 1'b0; praddr = 32'd0; prwd = 32'd0;
    repeat (3) @(posedge clk);
    model_reset();

    // Reset state.
    rd(BASE + 32'h0); check("rst_ctrl", ord, 32'd0); check("rst_irq", {31'd0, oirq}, 32'd0);
    rd(BASE + 32'h4); check("rst_preset", ord, 32'd0);
    rd(BASE + 32'h8); check("rst_count", ord, 32'd0);

    // One-shot, preset 3, interrupt enabled.
    wr(BASE + 32'h4, 32'd3);
    wr(BASE + 32'h0, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      rd(BASE + 32'h8);
      check("os_count", ord, (k >= 3) ? 32'(6 - k) : 32'd0);
      check("os_irq", {31'd0, oirq}, (k == 6) ? 32'd1 : 32'd0);
    end
    rd(BASE + 32'h0); check("os_ctrl_after", ord, 32'h8); check("os_irq_hold", {31'd0, oirq}, 32'd1);
    rd(BASE + 32'h0); check("os_irq_hold2", {31'd0, oirq}, 32'd1);
    wr(BASE + 32'h0, 32'h0); check("os_irq_before_clr", {31'd0, oirq}, 32'd1);
    rd(BASE + 32'h0); check("os_irq_cleared", {31'd0, oirq}, 32'd0);

    // Auto-reload: pulse every 5 cycles, EN stays set.
    wr(BASE + 32'h0, 32'hB);
    for (int k = 1; k <= 21; k++) begin
      rd(BASE + 32'h0);
      check("ar_ctrl", ord, 32'hB);
      check("ar_irq", {31'd0, oirq}, (k >= 6 && (k - 1) % 5 == 0) ? 32'd1 : 32'd0);
    end
    wr(BASE + 32'h0, 32'h0);
    repeat (4) rd(BASE + 32'h8);

    // Disable mid-count while COUNT becomes 2.
    wr(BASE + 32'h0, 32'h9);
    rd(BASE + 32'h8);
    rd(BASE + 32'h8);
    wr(BASE + 32'h0, 32'h8);
    for (int k = 0; k < 4; k++) begin
      rd(BASE + 32'h8);
      check("stop_count", ord, 32'd2);
      check("stop_irq", {31'd0, oirq}, 32'd0);
    end

    // Unmapped offsets and read-only COUNT.
    rd(BASE + 32'hC);  check("hole_rd", ord, 32'd0);
    rd(BASE + 32'h10); check("miss_rd", ord, 32'd0);
    wr(BASE + 32'h8, 32'hFFFF);
    rd(BASE + 32'h8);  check("count_ro", ord, 32'd2);
    wr(BASE + 32'h10, 32'h5);
    wr(BASE + 32'hC, 32'h5);
    rd(BASE + 32'h0);  check("ctrl_untouched", ord, 32'h8);
    rd(BASE + 32'h4);  check("preset_untouched", ord, 32'd3);

    // PRESET=0 times like PRESET=1.
    wr(BASE + 32'h4, 32'd0);
    wr(BASE + 32'h0, 32'h9);
    for (int k = 1; k <= 5; k++) begin
      rd(BASE + 32'h8);
      check("p0_count", ord, (k < 3) ? 32'd2 : 32'd0);
      check("p0_irq", {31'd0, oirq}, (k >= 4) ? 32'd1 : 32'd0);
    end
    wr(BASE + 32'h0, 32'h0);

    // Reset while COUNT=1.
    wr(BASE + 32'h4, 32'd3);
    wr(BASE + 32'h0, 32'h9);
    repeat (4) rd(BASE + 32'h8);
    step(1'b0, 1'b0, BASE + 32'h8, 32'd0);
    check("pre_rst_count", ord, 32'd1);
    rd(BASE + 32'h0); check("post_rst_ctrl", ord, 32'd0);
    rd(BASE + 32'h4); check("post_rst_preset", ord, 32'd0);
    rd(BASE + 32'h8); check("post_rst_count", ord, 32'd0);
    for (int k = 0; k < 6; k++) begin
      rd(BASE + 32'h8);
      check("post_rst_irq", {31'd0, oirq}, 32'd0);
    end

    // Randomized traffic; every cycle is compared against the model.
    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(0, 149) != 0);
      we  = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 6);
      case (sel)
        0, 1:    a = BASE + 32'h0;
        2:       a = BASE + 32'h4;
        3, 4:    a = BASE + 32'h8;
        5:       a = BASE + 32'hC;
        default: a = BASE + 32'h10 + 32'($urandom_range(0, 3));
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a[3:2] == 2'b01) d = 32'($urandom_range(0, 6));
      if (a[3:2] == 2'b00) d[0] = ($urandom_range(0, 3) != 0);
      step(r, we, a, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
